// File: rtl/uart_rx_fifo.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling FSM with parity and
// framing checks, feeding a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int C_SYSTEM_FREQ = 50_000_000,
    parameter int C_BAUDRATE    = 115_200,
    parameter int C_DATA_BITS   = 8,
    parameter int C_USE_PARITY  = 0,
    parameter int C_ODD_PARITY  = 0,
    parameter int C_STOP_BITS   = 1,
    parameter int C_FIFO_DEPTH  = 16
) (
    input  logic                              Clk,
    input  logic                              Resetn,
    input  logic                              RX,
    input  logic                              rd_uart_en,
    input  logic                              err_clr,
    output logic [C_DATA_BITS-1:0]            RX_data,
    output logic                              RX_perr,
    output logic                              RX_ferr,
    output logic                              Empty,
    output logic                              Full,
    output logic [$clog2(C_FIFO_DEPTH+1)-1:0] Count,
    output logic                              Overrun
);
    localparam int CPB = C_SYSTEM_FREQ / C_BAUDRATE;
    localparam int TW  = $clog2(CPB);
    localparam int PW  = $clog2(C_FIFO_DEPTH);
    localparam int CW  = $clog2(C_FIFO_DEPTH + 1);
    localparam int WW  = C_DATA_BITS + 2;

    localparam logic [TW-1:0] T_LAST    = TW'(CPB - 1);
    localparam logic [TW-1:0] T_MID     = TW'(CPB / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(C_DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(C_STOP_BITS - 1);
    localparam logic          ODD       = (C_ODD_PARITY != 0);
    localparam logic [CW-1:0] DEPTH     = CW'(C_FIFO_DEPTH);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic                   rx_m;
    logic                   rx_s;
    logic [TW-1:0]          timer;
    logic [3:0]             bit_cnt;
    logic [C_DATA_BITS-1:0] shreg;
    logic                   perr;
    logic                   ferr;
    logic                   ferr_next;
    logic                   push;
    logic [WW-1:0]          push_word;

    logic [WW-1:0]          mem [C_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    // The word is written on the same edge as the last stop-bit sample so it falls through next cycle
    assign ferr_next = ferr | ~rx_s;
    assign push      = (state == STOP) && (timer == T_LAST) && (bit_cnt == LAST_STOP);
    assign push_word = {ferr_next, perr, shreg};

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state   <= ARM;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rx_s) state <= IDLE;
                end
                IDLE: begin
                    if (!rx_s) begin
                        timer <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (timer == T_MID) begin
                        timer <= '0;
                        if (!rx_s) begin
                            bit_cnt <= '0;
                            perr    <= 1'b0;
                            ferr    <= 1'b0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        shreg <= {rx_s, shreg[C_DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (C_USE_PARITY != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PARITY: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        perr  <= (^shreg) ^ rx_s ^ ODD;
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        ferr  <= ferr_next;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            // A low line after a bad stop bit must not look like a new start bit
                            state   <= ferr_next ? ARM : IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    assign Empty = (count == '0);
    assign Full  = (count == DEPTH);
    assign Count = count;
    assign pop   = rd_uart_en & ~Empty;
    assign wr_en = push & (~Full | pop);
    assign drop  = push & Full & ~pop;

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            Overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)         Overrun <= 1'b1;
            else if (err_clr) Overrun <= 1'b0;
        end
    end

    assign {RX_ferr, RX_perr, RX_data} = Empty ? '0 : mem[rd_ptr];

endmodule
